aqed_fifo_harness: RTL and testbench

//  Parametrised A-QED self-consistency harness for memory cores in FIFO mode.
//  - Sits between a free formal/bench stimulus source and the FIFO under test.
//  - Picks one "original" write on exec_dup and later re-injects the same data as a "duplicate".
//  - Checks that both values leave the FIFO identical, and bounds the original's response time.
//  - Tracks occupancy so the DUT is never written when full or read when empty.

---
 rtl/aqed_fifo_harness.sv | 101 ++++++++++
 tb/tb_aqed_fifo_harness.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aqed_fifo_harness.sv
// aqed_fifo_harness: A-QED self-consistency harness that duplicates one FIFO write and compares both read-outs
module aqed_fifo_harness #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_W    = 16,
  parameter int SEQ_W      = 17,
  parameter int BOUND_MULT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               exec_dup,
  input  logic               ren_req,
  output logic [DATA_W-1:0]  dut_data_in,
  output logic               dut_wen,
  output logic               dut_ren,
  input  logic [DATA_W-1:0]  dut_data_out,
  input  logic               dut_valid_out,
  output logic               orig_issued,
  output logic               orig_done,
  output logic               qed_done,
  output logic               qed_check,
  output logic               resp_bound_fail
);
  localparam int RB_W = DEPTH_W + $clog2(BOUND_MULT) + 1;
  typedef enum logic [2:0] {IDLE, WAIT_ORIG, DUP_ISSUE, WAIT_DUP, DONE} state_t;
  state_t state, state_nxt;
  logic [DEPTH_W-1:0] occ;
  logic [SEQ_W-1:0] wr_seq, rd_seq, orig_idx, dup_idx;
  logic [DATA_W-1:0] orig_data, orig_out;
  logic [RB_W-1:0] rb_cnt, rb_nxt, bound;
  logic has_room, accept, dup_fire, out_v, capture, orig_hit, dup_hit;
  assign has_room = occ < depth;
  assign out_v    = clk_en && dut_valid_out;
  assign capture  = state == IDLE && exec_dup && accept && wr_seq != '1;
  assign orig_hit = state == WAIT_ORIG && out_v && rd_seq == orig_idx;
  assign dup_hit  = state == WAIT_DUP && out_v && rd_seq == dup_idx;
  assign bound    = RB_W'(BOUND_MULT) * RB_W'(depth);
  assign rb_nxt   = (orig_issued && !orig_done && dut_ren && rb_cnt != '1) ? rb_cnt + RB_W'(1) : rb_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      occ             <= '0;
      wr_seq          <= '0;
      rd_seq          <= '0;
      orig_idx        <= '0;
      dup_idx         <= '0;
      orig_data       <= '0;
      orig_out        <= '0;
      rb_cnt          <= '0;
      orig_issued     <= 1'b0;
      orig_done       <= 1'b0;
      qed_done        <= 1'b0;
      qed_check       <= 1'b0;
      resp_bound_fail <= 1'b0;
    end else if (clk_en) begin
      state  <= state_nxt;
      occ    <= occ + DEPTH_W'(dut_wen) - DEPTH_W'(dut_ren);
      wr_seq <= (dut_wen && wr_seq != '1) ? wr_seq + SEQ_W'(1) : wr_seq;
      rd_seq <= (out_v && rd_seq != '1) ? rd_seq + SEQ_W'(1) : rd_seq;
      rb_cnt <= rb_nxt;
      if (capture) begin
        orig_data   <= in_data;
        orig_idx    <= wr_seq;
        orig_issued <= 1'b1;
      end
      if (orig_hit) begin
        orig_out  <= dut_data_out;
        orig_done <= 1'b1;
      end
      if (dup_fire) dup_idx <= wr_seq;
      if (dup_hit) begin
        qed_check <= dut_data_out == orig_out;
        qed_done  <= 1'b1;
      end
      // uses the post-increment count so the flag rises the cycle after the bounding read
      if (orig_issued && !orig_done && rb_nxt >= bound) resp_bound_fail <= 1'b1;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = capture  ? WAIT_ORIG : IDLE;
      WAIT_ORIG: state_nxt = orig_hit ? DUP_ISSUE : WAIT_ORIG;
      DUP_ISSUE: state_nxt = dup_fire ? WAIT_DUP  : DUP_ISSUE;
      WAIT_DUP:  state_nxt = dup_hit  ? DONE      : WAIT_DUP;
      default:   state_nxt = DONE;
    endcase
  end
  always_comb begin
    in_ready    = clk_en && has_room && state != DUP_ISSUE;
    accept      = in_valid && in_ready;
    dup_fire    = clk_en && has_room && state == DUP_ISSUE;
    dut_wen     = accept || dup_fire;
    dut_data_in = dup_fire ? orig_data : in_data;
    dut_ren     = clk_en && ren_req && occ != '0;
  end
endmodule

// File: tb/tb_aqed_fifo_harness.sv
// tb_aqed_fifo_harness: randomized scoreboard bench with a queue-based FIFO and an event-level harness model
module tb_aqed_fifo_harness;
  logic clk = 1'b0;
  logic reset, clk_en, in_valid, in_ready, exec_dup, ren_req, dut_wen, dut_ren, dut_valid_out;
  logic orig_issued, orig_done, qed_done, qed_check, resp_bound_fail;
  logic [15:0] depth, in_data, dut_data_in, dut_data_out;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  aqed_fifo_harness dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .depth(depth), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .exec_dup(exec_dup), .ren_req(ren_req),
    .dut_data_in(dut_data_in), .dut_wen(dut_wen), .dut_ren(dut_ren),
    .dut_data_out(dut_data_out), .dut_valid_out(dut_valid_out),
    .orig_issued(orig_issued), .orig_done(orig_done), .qed_done(qed_done),
    .qed_check(qed_check), .resp_bound_fail(resp_bound_fail)
  );

  // FIFO under test: one-cycle read latency, optional data corruption or dropped valids
  logic [15:0] mem_q[$];
  int pop_n;
  int corrupt_idx = -1;
  bit vmask = 1'b1;
  always @(posedge clk) begin
    if (reset) begin
      mem_q.delete();
      pop_n         <= 0;
      dut_valid_out <= 1'b0;
      dut_data_out  <= '0;
    end else begin
      if (dut_ren && mem_q.size() > 0) begin
        dut_data_out <= (pop_n == corrupt_idx) ? 16'hFFFF : mem_q[0];
        void'(mem_q.pop_front());
        pop_n <= pop_n + 1;
      end
      dut_valid_out <= dut_ren && vmask;
      if (dut_wen) mem_q.push_back(dut_data_in);
    end
  end

  typedef struct {
    logic ir, wen, ren;
    logic [15:0] wd;
    logic [4:0] fl;
  } rec_t;
  rec_t sb[$];

  // event-level model: indices of writes/reads and which checks have completed
  int m_occ, m_wr, m_rd, m_pop, m_orig_idx, m_dup_idx, m_rb;
  logic [15:0] m_wl[$];
  logic [15:0] m_orig_data, m_orig_out, m_pend_data;
  bit m_pend, m_iss, m_odone, m_qdone, m_qchk, m_rbf, corrupt_dup;

  task automatic m_reset();
    m_occ = 0; m_wr = 0; m_rd = 0; m_pop = 0; m_rb = 0;
    m_orig_idx = -1; m_dup_idx = -1;
    m_wl.delete();
    m_orig_data = 0; m_orig_out = 0; m_pend_data = 0;
    m_pend = 0; m_iss = 0; m_odone = 0; m_qdone = 0; m_qchk = 0; m_rbf = 0;
    corrupt_dup = 0; corrupt_idx = -1; vmask = 1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit v, input bit rq, input bit dup, input bit en, input logic [15:0] d);
    bit dp, ir, fire, acc, wen, rn;
    logic [15:0] wd, nd;
    @(posedge clk); #1;
    clk_en = en; in_valid = v; ren_req = rq; exec_dup = dup; in_data = d;
    #1;
    nd   = 0;
    dp   = m_odone && m_dup_idx < 0;
    ir   = en && m_occ < int'(depth) && !dp;
    fire = en && dp && m_occ < int'(depth);
    acc  = v && ir;
    wen  = acc || fire;
    wd   = fire ? m_orig_data : d;
    rn   = en && rq && m_occ > 0;
    sb.push_back('{ir, wen, rn, wd, {m_iss, m_odone, m_qdone, m_qchk, m_rbf}});
    if (fire && corrupt_dup) corrupt_idx = m_wr;
    if (en) begin
      if (m_iss && !m_odone && rn) m_rb++;
      if (m_iss && !m_odone && m_rb >= 4 * int'(depth)) m_rbf = 1;
      if (m_pend) begin
        if (m_orig_idx >= 0 && !m_odone && m_rd == m_orig_idx) begin
          m_odone = 1; m_orig_out = m_pend_data;
        end else if (m_dup_idx >= 0 && !m_qdone && m_rd == m_dup_idx) begin
          m_qdone = 1; m_qchk = (m_pend_data == m_orig_out);
        end
        m_rd++;
      end
      if (m_orig_idx < 0 && dup && acc) begin
        m_orig_idx = m_wr; m_orig_data = d; m_iss = 1;
      end
      if (fire) m_dup_idx = m_wr;
      if (rn) begin
        nd = (m_pop == corrupt_idx) ? 16'hFFFF : m_wl.pop_front();
        if (m_pop == corrupt_idx) void'(m_wl.pop_front());
        m_pop++;
      end
      if (wen) begin m_wl.push_back(wd); m_wr++; end
      m_occ += int'(wen) - int'(rn);
    end
    m_pend = rn && vmask;
    m_pend_data = nd;
  endtask

  task automatic rnd(input int pv, input int pr, input int pd, input int pe);
    cycle($urandom_range(99) < pv, $urandom_range(99) < pr, $urandom_range(99) < pd,
          $urandom_range(99) < pe, 16'($urandom));
  endtask

  task automatic do_reset(input int dep);
    @(posedge clk); #1;
    reset = 1; depth = 16'(dep); clk_en = 1; in_valid = 0; ren_req = 0; exec_dup = 0; in_data = 0;
    @(posedge clk); #1;
    reset = 0;
    m_reset();
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("in_ready", 16'(in_ready), 16'(r.ir));
        chk("dut_wen", 16'(dut_wen), 16'(r.wen));
        chk("dut_ren", 16'(dut_ren), 16'(r.ren));
        if (r.wen) chk("dut_data_in", dut_data_in, r.wd);
        chk("flags", 16'({orig_issued, orig_done, qed_done, qed_check, resp_bound_fail}), 16'(r.fl));
      end
    end
  end

  initial begin : driver
    do_reset(4);
    chk("reset_flags", 16'({orig_issued, orig_done, qed_done, qed_check, resp_bound_fail}), 16'h0);
    chk("reset_ready", 16'({dut_wen, dut_ren}), 16'h0);
    // matching duplicate
    cycle(1, 0, 1, 1, 16'h1234);
    for (int i = 0; i < 300 && !qed_done; i++) rnd(60, 50, 0, 100);
    chk("t1_qed_done", 16'(qed_done), 16'h1);
    chk("t1_qed_check", 16'(qed_check), 16'h1);
    chk("t1_rbf", 16'(resp_bound_fail), 16'h0);
    // corrupted duplicate read
    do_reset(4);
    corrupt_dup = 1;
    cycle(1, 0, 1, 1, 16'h1234);
    for (int i = 0; i < 300 && !qed_done; i++) rnd(60, 50, 0, 100);
    chk("t2_qed_done", 16'(qed_done), 16'h1);
    chk("t2_qed_check", 16'(qed_check), 16'h0);
    // full FIFO with no reads
    do_reset(2);
    cycle(1, 0, 0, 1, 16'hAAAA);
    cycle(1, 0, 1, 1, 16'h5555);
    repeat (20) rnd(100, 0, 50, 100);
    chk("t3_full_ready", 16'(in_ready), 16'h0);
    for (int i = 0; i < 200 && !qed_done; i++) rnd(50, 70, 0, 100);
    chk("t3_qed_done", 16'(qed_done), 16'h1);
    // original never returned
    do_reset(2);
    vmask = 0;
    cycle(1, 0, 1, 1, 16'hBEEF);
    for (int i = 0; i < 200 && !resp_bound_fail; i++) rnd(70, 70, 0, 100);
    chk("t4_rbf", 16'(resp_bound_fail), 16'h1);
    chk("t4_orig_done", 16'(orig_done), 16'h0);
    // simultaneous write+read, exec_dup without a write, random enable
    do_reset(4);
    cycle(0, 0, 1, 1, 16'h0);
    cycle(1, 0, 0, 1, 16'h0001);
    cycle(1, 1, 0, 1, 16'h0002);
    chk("t5_no_orig", 16'(orig_issued), 16'h0);
    repeat (3) cycle(1, 0, 0, 1, 16'($urandom));
    for (int i = 0; i < 500; i++) rnd(60, 50, 10, 80);
    chk("t5_done_or_busy", 16'(qed_done | orig_issued), 16'h1);
    // reset during WAIT_DUP, then a fresh check
    do_reset(4);
    cycle(1, 0, 1, 1, 16'hC0DE);
    for (int i = 0; i < 300 && m_dup_idx < 0; i++) rnd(60, 50, 0, 100);
    chk("t6_reached_dup", 16'(m_dup_idx >= 0), 16'h1);
    do_reset(4);
    chk("t6_reset_flags", 16'({orig_issued, orig_done, qed_done, qed_check, resp_bound_fail}), 16'h0);
    cycle(1, 0, 1, 1, 16'h7777);
    for (int i = 0; i < 300 && !qed_done; i++) rnd(60, 50, 0, 100);
    chk("t6_qed_done", 16'(qed_done), 16'h1);
    chk("t6_qed_check", 16'(qed_check), 16'h1);
    // zero depth blocks all writes
    do_reset(0);
    repeat (30) rnd(100, 50, 50, 100);
    chk("t7_ready", 16'(in_ready), 16'h0);
    chk("t7_orig", 16'(orig_issued), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
